rv32v_elem_sequencer: RTL
=========================

Name: rv32v_elem_sequencer

Overview:
- Upstream of the vector decode/execute pipeline register.
- Turns one accepted vector instruction into a stream of two-lane element groups.
- Each group drives the per-lane element offsets (woffset0/woffset1), the register-group offset, the lane write enables (wen[1:0]) and the decode_done flag seen by execute.
- Holds on stall, aborts on flush, handles vstart/vl boundaries and widening/narrowing element size.

Parameters:
- VLEN, 128, vector register length in bits.
- VL_WIDTH, 7, element-index MSB; indices are [VL_WIDTH:0] (max 255 elements, covers LMUL=8 at SEW=8).

Ports:
- CLK  input  1  clock
- RST  input  1  synchronous active-high reset
- start  input  1  pulse: new vector instruction accepted by decode
- vl  input  32  active vector length; only bits [VL_WIDTH:0] used
- vstart  input  32  first element index; only bits [VL_WIDTH:0] used
- sew  input  2  0=8b, 1=16b, 2=32b, 3=reserved
- vd_widen  input  1  destination is 2*SEW
- vd_narrow  input  1  source vs2 is 2*SEW
- stall  input  1  downstream not accepting; hold current group
- flush  input  1  abort current instruction
- busy  output  1  sequencer in RUN
- woffset0  output  VL_WIDTH+1  lane-0 element position within its register
- woffset1  output  VL_WIDTH+1  lane-1 element position within its register
- vreg_off0  output  3  lane-0 register index within group (added to vd/vs by decode)
- vreg_off1  output  3  lane-1 register index within group
- wen  output  2  per-lane element valid/write enable
- decode_done  output  1  current group is the instruction's last
- ill_sew  output  1  one-cycle pulse: illegal effective SEW, no groups issued

Behaviour:
- Reset (RST=1 at posedge):
  - state=IDLE, idx=0, ecnt=0, epr_log=0.
  - All outputs 0.
  - RST overrides start, flush and an in-progress RUN.
- Effective SEW: eff = sew + (vd_widen | vd_narrow).
  - Illegal if sew==3 or eff>2. On start, ill_sew pulses the next cycle and state stays IDLE.
- Elements per register (registered at start):
  - epr = VLEN / (8 << eff) = 16/8/4 for eff = 0/1/2.
  - Stored as epr_log = 4 - eff.
- Latched at start: vl_q = vl[VL_WIDTH:0], idx = vstart[VL_WIDTH:0].
- IDLE:
  - start with legal SEW and vstart < vl → RUN; first group visible the cycle after start.
  - start with legal SEW and vstart >= vl (including vl=0) → EMPTY.
- EMPTY (1 cycle): wen=00, decode_done=1, busy=0 → IDLE.
- RUN outputs (combinational from registered idx):
  - woffset0 = idx mod epr; woffset1 = (idx+1) mod epr.
  - vreg_off0 = idx >> epr_log; vreg_off1 = (idx+1) >> epr_log.
  - wen[0] = 1; wen[1] = (idx+1 < vl_q).
  - decode_done = (idx+2 >= vl_q); busy = 1.
- RUN advance, when stall=0:
  - decode_done=1 → IDLE, outputs 0 next cycle.
  - Otherwise idx += 2.
- RUN hold, when stall=1: idx, state and all outputs hold, including decode_done.
- Odd vstart: lane 0 starts at vstart. Groups are never re-aligned to even indices.
- Register-boundary crossing within a group is legal: the two lanes may carry different vreg_off (e.g. idx=15 at epr=16 gives vreg_off0=0, vreg_off1=1).
- start while busy is ignored; latched parameters are unchanged.
- Priority: RST > flush > stall > advance.
  - flush in any state → IDLE next cycle with all outputs 0.
  - flush together with start: flush wins and start is dropped.
- idx arithmetic is VL_WIDTH+2 bits wide, so idx+2 never wraps.

Test Plan:
- sew=2, vl=7, vstart=0, no stall → 4 groups over cycles 1–4: idx 0,2,4,6; last group wen=01, decode_done=1; vreg_off0 = 0,0,1,1; busy drops in cycle 5.
- sew=0, vl=20, vstart=3 → first group woffset0=3, woffset1=4; group at idx=15 gives woffset=(15,0), vreg_off=(0,1); last group idx=19, wen=01, done=1.
- sew=1, vd_widen=1, vl=8 → epr=4; groups at idx 0,2,4,6 give vreg_off0 = 0,0,1,1; 4 groups total, last wen=11 with done=1.
- vl=16, stall held high 3 cycles on the second group → outputs frozen 3 cycles and resume at idx=4; total elapsed 8+3 cycles.
- vstart=5, vl=5 → EMPTY cycle: wen=00, done=1, busy=0.
- sew=2 with vd_widen=1 → ill_sew pulse, no groups.
- Mid-RUN flush asserted simultaneously with start → IDLE and outputs 0 next cycle; new start ignored.
- RST mid-RUN → same result as flush.

Source files
------------

// File: rtl/rv32v_elem_sequencer_if.sv
// Handshake bundle between vector decode and the element sequencer.
// The master side issues instructions and stall/flush; the slave side
// (the sequencer) returns the per-group element stream.
interface rv32v_elem_sequencer_if #(
  parameter int VL_WIDTH = 7
);
  logic                start;
  logic [31:0]         vl;
  logic [31:0]         vstart;
  logic [1:0]          sew;
  logic                vd_widen;
  logic                vd_narrow;
  logic                stall;
  logic                flush;
  logic                busy;
  logic [VL_WIDTH:0]   woffset0;
  logic [VL_WIDTH:0]   woffset1;
  logic [2:0]          vreg_off0;
  logic [2:0]          vreg_off1;
  logic [1:0]          wen;
  logic                decode_done;
  logic                ill_sew;

  modport master (
    output start, vl, vstart, sew, vd_widen, vd_narrow, stall, flush,
    input  busy, woffset0, woffset1, vreg_off0, vreg_off1, wen, decode_done, ill_sew
  );

  modport slave (
    input  start, vl, vstart, sew, vd_widen, vd_narrow, stall, flush,
    output busy, woffset0, woffset1, vreg_off0, vreg_off1, wen, decode_done, ill_sew
  );
endinterface

// File: rtl/rv32v_elem_sequencer.sv
// Vector element sequencer: turns one accepted vector instruction into a
// stream of two-lane element groups (offsets, register-group offsets, lane
// enables, last-group flag). Holds on stall, aborts on flush, and handles
// vstart/vl boundaries plus widening/narrowing element size.
module rv32v_elem_sequencer #(
  parameter int VLEN     = 128,
  parameter int VL_WIDTH = 7
) (
  input logic                   CLK,
  input logic                   RST,
  rv32v_elem_sequencer_if.slave bus
);

  localparam int IW = VL_WIDTH + 2;
  localparam logic [3:0] BASE_LOG = 4'($clog2(VLEN / 8));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    EMPTY = 2'd2
  } state_t;

  state_t            state;
  logic [IW-1:0]     idx;
  logic [VL_WIDTH:0] vl_q;
  logic [3:0]        epr_log;
  logic              ill_q;

  logic [2:0]        eff;
  logic              sew_illegal;
  logic [VL_WIDTH:0] vl_in;
  logic [VL_WIDTH:0] vstart_in;
  logic [IW-1:0]     idx1;
  logic [IW-1:0]     idx2;
  logic [VL_WIDTH:0] off_mask;
  logic [IW-1:0]     shift0;
  logic [IW-1:0]     shift1;
  logic              lane1_valid;
  logic              last_group;
  logic              unused_bits;

  // Decode the incoming instruction: effective SEW, legality and the
  // element-index fields actually used from vl/vstart.
  always_comb begin
    eff         = {1'b0, bus.sew} + {2'b00, (bus.vd_widen | bus.vd_narrow)};
    sew_illegal = (bus.sew == 2'd3) || (eff > 3'd2);
    vl_in       = bus.vl[VL_WIDTH:0];
    vstart_in   = bus.vstart[VL_WIDTH:0];
  end

  // Group geometry from the registered index: lane offsets within a
  // register, register index within the group, lane-1 validity and
  // whether this group is the last one of the instruction.
  always_comb begin
    idx1        = idx + IW'(1);
    idx2        = idx + IW'(2);
    off_mask    = ~({(VL_WIDTH+1){1'b1}} << epr_log);
    shift0      = idx >> epr_log;
    shift1      = idx1 >> epr_log;
    lane1_valid = idx1 < {1'b0, vl_q};
    last_group  = idx2 >= {1'b0, vl_q};
  end

  assign unused_bits = &{1'b0, shift0[IW-1:3], shift1[IW-1:3],
                         bus.vl[31:VL_WIDTH+1], bus.vstart[31:VL_WIDTH+1]};

  // Sequencer FSM: reset beats flush beats stall beats advance; a new
  // instruction is only accepted from IDLE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      idx     <= '0;
      vl_q    <= '0;
      epr_log <= '0;
      ill_q   <= 1'b0;
    end else if (bus.flush) begin
      state <= IDLE;
      idx   <= '0;
      ill_q <= 1'b0;
    end else begin
      ill_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (sew_illegal) begin
              ill_q <= 1'b1;
            end else begin
              vl_q    <= vl_in;
              idx     <= {1'b0, vstart_in};
              epr_log <= BASE_LOG - {1'b0, eff};
              state   <= (vstart_in < vl_in) ? RUN : EMPTY;
            end
          end
        end
        RUN: begin
          if (!bus.stall) begin
            if (last_group) begin
              state <= IDLE;
              idx   <= '0;
            end else begin
              idx <= idx2;
            end
          end
        end
        EMPTY: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Drive the group outputs; everything is zero outside RUN except the
  // single-cycle done flag of an empty instruction and the ill_sew pulse.
  always_comb begin
    bus.busy        = 1'b0;
    bus.woffset0    = '0;
    bus.woffset1    = '0;
    bus.vreg_off0   = '0;
    bus.vreg_off1   = '0;
    bus.wen         = 2'b00;
    bus.decode_done = 1'b0;
    bus.ill_sew     = ill_q;
    case (state)
      RUN: begin
        bus.busy        = 1'b1;
        bus.woffset0    = idx[VL_WIDTH:0] & off_mask;
        bus.woffset1    = idx1[VL_WIDTH:0] & off_mask;
        bus.vreg_off0   = shift0[2:0];
        bus.vreg_off1   = shift1[2:0];
        bus.wen         = {lane1_valid, 1'b1};
        bus.decode_done = last_group;
      end
      EMPTY: begin
        bus.decode_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
